// File: rtl/store_buf_pkg.sv
// Shared constants and FSM encoding for the store buffer.
package store_buf_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef enum logic [1:0] {
    SB_IDLE    = 2'd0,
    SB_RD_WAIT = 2'd1,
    SB_WR_WAIT = 2'd2
  } sb_state_e;

endpackage

// File: rtl/store_buf_fifo.sv
// Store-buffer entry storage: circular FIFO, load-conflict compare, optional
// merge into the youngest entry (enabled by STORE_BUF_MERGE_EN).
module store_buf_fifo
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_i,
  input  logic [ADDR_W-3:0] wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [3:0]        wr_be_i,
  output logic              wr_rdy_o,
  input  logic              pop_i,
  input  logic              head_busy_i,
  input  logic [ADDR_W-3:0] rd_word_i,
  output logic              conflict_o,
  output logic              empty_o,
  output logic [ADDR_W-3:0] head_word_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [3:0]        head_be_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-3:0] word_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [3:0]        be_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, merge_hit, alloc;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

`ifdef STORE_BUF_MERGE_EN
  logic [PTR_W-1:0]  youngest;
  logic [DATA_W-1:0] merged_data;

  assign youngest  = tail_q - PTR_W'(1);
  // An entry being issued or already on the cache port must stay frozen.
  assign merge_hit = wr_req_i && valid_q[youngest] && (word_q[youngest] == wr_word_i)
                     && !(head_busy_i && (youngest == head_q));

  always_comb begin
    merged_data = data_q[youngest];
    for (int b = 0; b < 4; b++) begin
      if (wr_be_i[b]) merged_data[b*8 +: 8] = wr_data_i[b*8 +: 8];
    end
  end
`else
  logic unused_head_busy;
  assign unused_head_busy = head_busy_i;
  assign merge_hit        = 1'b0;
`endif

  assign wr_rdy_o = !full || merge_hit;
  assign alloc    = wr_req_i && !full && !merge_hit;

  // Any pending store request counts, accepted or not, so the issue decision
  // never depends on the merge/ready path.
  always_comb begin
    conflict_o = wr_req_i && (wr_word_i == rd_word_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (word_q[i] == rd_word_i)) conflict_o = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    unique case ({alloc, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload arrays carry no reset; valid_q alone decides whether an entry exists.
  always_ff @(posedge clk) begin
    if (alloc) begin
      word_q[tail_q] <= wr_word_i;
      data_q[tail_q] <= wr_data_i;
      be_q[tail_q]   <= wr_be_i;
    end
`ifdef STORE_BUF_MERGE_EN
    else if (merge_hit) begin
      data_q[youngest] <= merged_data;
      be_q[youngest]   <= be_q[youngest] | wr_be_i;
    end
`endif
  end

  assign head_word_o = word_q[head_q];
  assign head_data_o = data_q[head_q];
  assign head_be_o   = be_q[head_q];

endmodule

// File: rtl/store_buf.sv
// Write buffer between LSU and cache_top: one cache access in flight, loads
// bypass non-conflicting stores. Optional store merging: STORE_BUF_MERGE_EN.
module store_buf
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_wr_req_i,
  input  logic [ADDR_W-1:0] lsu_wr_addr_i,
  input  logic [DATA_W-1:0] lsu_wr_data_i,
  input  logic [3:0]        lsu_wr_en_i,
  output logic              lsu_wr_rdy_o,
  input  logic              lsu_rd_req_i,
  input  logic [ADDR_W-1:0] lsu_rd_addr_i,
  output logic [DATA_W-1:0] lsu_rd_data_o,
  output logic              lsu_rd_vld_o,
  output logic              lsu_stall_o,
  output logic              sb_empty_o,
  output logic              cpu_rd_req_o,
  output logic              cpu_wr_req_o,
  output logic [ADDR_W-1:0] cpu_rd_addr_o,
  output logic [ADDR_W-1:0] cpu_wr_addr_o,
  output logic [DATA_W-1:0] cpu_wr_data_o,
  output logic [3:0]        cpu_wr_en_o,
  input  logic [DATA_W-1:0] cpu_rd_data_i,
  input  logic              cache_data_ack_i
);

  sb_state_e         state_q, state_d;
  logic              rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, rd_data_q, rd_data_d;
  logic [3:0]        wr_en_q, wr_en_d;

  logic              conflict, fifo_empty, pop, load_go, drain_go;
  logic [ADDR_W-3:0] head_word;
  logic [DATA_W-1:0] head_data;
  logic [3:0]        head_be;
  logic              unused_wr_offset;

  assign unused_wr_offset = ^lsu_wr_addr_i[1:0];

  // rd_vld_q blocks re-issue while the LSU still holds the completing request.
  assign load_go  = (state_q == SB_IDLE) && lsu_rd_req_i && !rd_vld_q && !conflict;
  assign drain_go = (state_q == SB_IDLE) && !load_go && !fifo_empty;
  assign pop      = (state_q == SB_WR_WAIT) && cache_data_ack_i;

  store_buf_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_req_i   (lsu_wr_req_i),
    .wr_word_i  (lsu_wr_addr_i[ADDR_W-1:2]),
    .wr_data_i  (lsu_wr_data_i),
    .wr_be_i    (lsu_wr_en_i),
    .wr_rdy_o   (lsu_wr_rdy_o),
    .pop_i      (pop),
    .head_busy_i((state_q == SB_WR_WAIT) || drain_go),
    .rd_word_i  (lsu_rd_addr_i[ADDR_W-1:2]),
    .conflict_o (conflict),
    .empty_o    (fifo_empty),
    .head_word_o(head_word),
    .head_data_o(head_data),
    .head_be_o  (head_be)
  );

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d   = state_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = wr_en_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    unique case (state_q)
      SB_IDLE: begin
        if (load_go) begin
          rd_req_d  = 1'b1;
          rd_addr_d = lsu_rd_addr_i;
          state_d   = SB_RD_WAIT;
        end else if (drain_go) begin
          wr_req_d  = 1'b1;
          wr_addr_d = {head_word, 2'b00};
          wr_data_d = head_data;
          wr_en_d   = head_be;
          state_d   = SB_WR_WAIT;
        end
      end
      SB_RD_WAIT: begin
        if (cache_data_ack_i) begin
          rd_req_d  = 1'b0;
          rd_vld_d  = 1'b1;
          rd_data_d = cpu_rd_data_i;
          state_d   = SB_IDLE;
        end
      end
      SB_WR_WAIT: begin
        if (cache_data_ack_i) begin
          wr_req_d = 1'b0;
          state_d  = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SB_IDLE;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign cpu_rd_req_o  = rd_req_q;
  assign cpu_wr_req_o  = wr_req_q;
  assign cpu_rd_addr_o = rd_addr_q;
  assign cpu_wr_addr_o = wr_addr_q;
  assign cpu_wr_data_o = wr_data_q;
  assign cpu_wr_en_o   = wr_en_q;
  assign lsu_rd_data_o = rd_data_q;
  assign lsu_rd_vld_o  = rd_vld_q;
  assign sb_empty_o    = fifo_empty && (state_q == SB_IDLE);
  assign lsu_stall_o   = (lsu_rd_req_i && !lsu_rd_vld_o) || (lsu_wr_req_i && !lsu_wr_rdy_o);

endmodule

// File: tb/tb_store_buf.sv
// Directed bench for store_buf with a cache model and write/read scoreboards;
// merge expectations follow STORE_BUF_MERGE_EN.
module tb_store_buf;
  import store_buf_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_wr_req_i = 1'b0;
  logic [31:0] lsu_wr_addr_i = '0;
  logic [31:0] lsu_wr_data_i = '0;
  logic [3:0]  lsu_wr_en_i = '0;
  logic        lsu_wr_rdy_o;
  logic        lsu_rd_req_i = 1'b0;
  logic [31:0] lsu_rd_addr_i = '0;
  logic [31:0] lsu_rd_data_o;
  logic        lsu_rd_vld_o;
  logic        lsu_stall_o;
  logic        sb_empty_o;
  logic        cpu_rd_req_o;
  logic        cpu_wr_req_o;
  logic [31:0] cpu_rd_addr_o;
  logic [31:0] cpu_wr_addr_o;
  logic [31:0] cpu_wr_data_o;
  logic [3:0]  cpu_wr_en_o;
  logic [31:0] cpu_rd_data_i = '0;
  logic        cache_data_ack_i = 1'b0;

  int          vectors = 0;
  int          errors  = 0;
  wr_exp_t     wq[$];
  logic [31:0] rq[$];
  logic [31:0] mem [logic [29:0]];

  always #5 clk = ~clk;

  store_buf dut (
    .clk             (clk),
    .rst             (rst),
    .lsu_wr_req_i    (lsu_wr_req_i),
    .lsu_wr_addr_i   (lsu_wr_addr_i),
    .lsu_wr_data_i   (lsu_wr_data_i),
    .lsu_wr_en_i     (lsu_wr_en_i),
    .lsu_wr_rdy_o    (lsu_wr_rdy_o),
    .lsu_rd_req_i    (lsu_rd_req_i),
    .lsu_rd_addr_i   (lsu_rd_addr_i),
    .lsu_rd_data_o   (lsu_rd_data_o),
    .lsu_rd_vld_o    (lsu_rd_vld_o),
    .lsu_stall_o     (lsu_stall_o),
    .sb_empty_o      (sb_empty_o),
    .cpu_rd_req_o    (cpu_rd_req_o),
    .cpu_wr_req_o    (cpu_wr_req_o),
    .cpu_rd_addr_o   (cpu_rd_addr_o),
    .cpu_wr_addr_o   (cpu_wr_addr_o),
    .cpu_wr_data_o   (cpu_wr_data_o),
    .cpu_wr_en_o     (cpu_wr_en_o),
    .cpu_rd_data_i   (cpu_rd_data_i),
    .cache_data_ack_i(cache_data_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a store and hold it until it is taken; optionally log the expected cache write.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit push);
    bit ok;
    ok = 1'b0;
    lsu_wr_req_i  = 1'b1;
    lsu_wr_addr_i = a;
    lsu_wr_data_i = d;
    lsu_wr_en_i   = be;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = lsu_wr_rdy_o;
      step();
    end
    lsu_wr_req_i = 1'b0;
    if (!ok) check("store_timeout", 32'(ok), 32'd1);
    if (push) wq.push_back('{addr: a, data: d, be: be});
  endtask

  // Cache side of a write: compare against the scoreboard, update the model, ack.
  task automatic ack_wr(input string tag);
    bit      seen;
    wr_exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      seen = cpu_wr_req_o;
      if (!seen) step();
    end
    check({tag, "_wr_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_no_rd"}, 32'(cpu_rd_req_o), 32'd0);
    if (wq.size() == 0) begin
      check({tag, "_wq_empty"}, 32'(wq.size()), 32'd1);
      e = '{addr: 32'hFFFF_FFFF, data: 32'hFFFF_FFFF, be: 4'hF};
    end else begin
      e = wq.pop_front();
    end
    check({tag, "_wr_addr"}, cpu_wr_addr_o, e.addr);
    check({tag, "_wr_data"}, cpu_wr_data_o, e.data);
    check({tag, "_wr_be"}, 32'(cpu_wr_en_o), 32'(e.be));
    if (!mem.exists(cpu_wr_addr_o[31:2])) mem[cpu_wr_addr_o[31:2]] = '0;
    for (int b = 0; b < 4; b++) begin
      if (cpu_wr_en_o[b]) mem[cpu_wr_addr_o[31:2]][b*8 +: 8] = cpu_wr_data_o[b*8 +: 8];
    end
    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
  endtask

  // Cache side of a read: return model data, then check the LSU-side completion.
  task automatic ack_rd(input string tag, input logic [31:0] a);
    bit          seen;
    logic [31:0] exp;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      seen = cpu_rd_req_o;
      if (!seen) step();
    end
    check({tag, "_rd_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_rd_addr"}, cpu_rd_addr_o, a);
    check({tag, "_stall"}, 32'(lsu_stall_o), 32'd1);
    cpu_rd_data_i    = mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
    cpu_rd_data_i    = '0;
    exp = (rq.size() != 0) ? rq.pop_front() : 32'hFFFF_FFFF;
    check({tag, "_vld"}, 32'(lsu_rd_vld_o), 32'd1);
    check({tag, "_data"}, lsu_rd_data_o, exp);
    check({tag, "_rdreq_drop"}, 32'(cpu_rd_req_o), 32'd0);
    lsu_rd_req_i = 1'b0;
    step();
    check({tag, "_vld_pulse"}, 32'(lsu_rd_vld_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_rdy"}, 32'(lsu_wr_rdy_o), 32'd1);
    check({tag, "_empty"}, 32'(sb_empty_o), 32'd1);
    check({tag, "_cpu_rd_req"}, 32'(cpu_rd_req_o), 32'd0);
    check({tag, "_cpu_wr_req"}, 32'(cpu_wr_req_o), 32'd0);
    check({tag, "_cpu_wr_addr"}, cpu_wr_addr_o, 32'd0);
    check({tag, "_cpu_wr_data"}, cpu_wr_data_o, 32'd0);
    check({tag, "_cpu_wr_en"}, 32'(cpu_wr_en_o), 32'd0);
    check({tag, "_cpu_rd_addr"}, cpu_rd_addr_o, 32'd0);
    check({tag, "_rd_vld"}, 32'(lsu_rd_vld_o), 32'd0);
    check({tag, "_rd_data"}, lsu_rd_data_o, 32'd0);
    check({tag, "_stall"}, 32'(lsu_stall_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Fill: four stores with the cache stalled, then a fifth is refused.
    store(32'h100, 32'hA000_0100, 4'hF, 1'b1);
    store(32'h104, 32'hA000_0104, 4'hF, 1'b1);
    store(32'h108, 32'hA000_0108, 4'hF, 1'b1);
    store(32'h10C, 32'hA000_010C, 4'hF, 1'b1);
    lsu_wr_req_i  = 1'b1;
    lsu_wr_addr_i = 32'h110;
    lsu_wr_data_i = 32'hA000_0110;
    lsu_wr_en_i   = 4'hF;
    #1;
    check("full_rdy", 32'(lsu_wr_rdy_o), 32'd0);
    check("full_stall", 32'(lsu_stall_o), 32'd1);
    check("full_not_empty", 32'(sb_empty_o), 32'd0);
    lsu_wr_req_i = 1'b0;
    for (int i = 0; i < 4; i++) ack_wr("fill");
    step();
    check("fill_drained", 32'(sb_empty_o), 32'd1);

    // Bypass: a non-conflicting load goes out ahead of a pending store.
    mem[30'(32'h300 >> 2)] = 32'hDEAD_BEEF;
    store(32'h200, 32'h0000_0200, 4'hF, 1'b1);
    lsu_rd_req_i  = 1'b1;
    lsu_rd_addr_i = 32'h300;
    rq.push_back(32'hDEAD_BEEF);
    step();
    check("bypass_rd_first", 32'(cpu_rd_req_o), 32'd1);
    check("bypass_wr_held", 32'(cpu_wr_req_o), 32'd0);
    ack_rd("bypass", 32'h300);
    ack_wr("bypass");
    step();

    // Conflict: a load to the same word waits for the store to reach the cache.
    store(32'h400, 32'hAABB_CCDD, 4'hF, 1'b1);
    lsu_rd_req_i  = 1'b1;
    lsu_rd_addr_i = 32'h402;
    rq.push_back(32'hAABB_CCDD);
    step();
    check("conflict_wr_first", 32'(cpu_wr_req_o), 32'd1);
    check("conflict_rd_held", 32'(cpu_rd_req_o), 32'd0);
    ack_wr("conflict");
    ack_rd("conflict", 32'h402);
    step();

    // Same-cycle store and load to one word count as a conflict.
    lsu_rd_req_i  = 1'b1;
    lsu_rd_addr_i = 32'h500;
    rq.push_back(32'h1234_5678);
    store(32'h500, 32'h1234_5678, 4'hF, 1'b1);
    check("same_cycle_rd_held", 32'(cpu_rd_req_o), 32'd0);
    ack_wr("same_cycle");
    ack_rd("same_cycle", 32'h500);
    step();

    // Merge: two partial stores to one word while a read keeps the port busy.
    mem[30'(32'h700 >> 2)] = 32'h0BAD_F00D;
    lsu_rd_req_i  = 1'b1;
    lsu_rd_addr_i = 32'h700;
    rq.push_back(32'h0BAD_F00D);
    step();
`ifdef STORE_BUF_MERGE_EN
    store(32'h600, 32'h1122_3344, 4'b0011, 1'b0);
    store(32'h600, 32'h5566_7788, 4'b1100, 1'b0);
    wq.push_back('{addr: 32'h600, data: 32'h5566_3344, be: 4'b1111});
`else
    store(32'h600, 32'h1122_3344, 4'b0011, 1'b1);
    store(32'h600, 32'h5566_7788, 4'b1100, 1'b1);
`endif
    ack_rd("merge_rd", 32'h700);
    while (wq.size() != 0) ack_wr("merge");
    step();
    check("merge_done_empty", 32'(sb_empty_o), 32'd1);

    // Reset while a write is in flight with three entries queued.
    store(32'h800, 32'h0000_0800, 4'hF, 1'b0);
    store(32'h804, 32'h0000_0804, 4'hF, 1'b0);
    store(32'h808, 32'h0000_0808, 4'hF, 1'b0);
    check("pre_reset_wr_busy", 32'(cpu_wr_req_o), 32'd1);
    check("pre_reset_wr_addr", cpu_wr_addr_o, 32'h800);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    step();
    step();
    check("post_reset_idle", 32'(cpu_wr_req_o), 32'd0);
    check("post_reset_empty", 32'(sb_empty_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
